// File: rtl/multicycle_control_unit.sv
// Multi-cycle control unit for the SimpleCPU datapath: steps each instruction
// through IF/ID/EXE/MEM/WB, drives the datapath selects and counts retired instructions.
module multicycle_control_unit #(
  parameter int unsigned CNT_W = 32
) (
  input  logic             CLK,
  input  logic             Reset,
  input  logic [5:0]       opcode,
  input  logic             zero,
  output logic             PCWre,
  output logic             InsMemRW,
  output logic             IRWre,
  output logic             ExtSel,
  output logic             ALUSrcA,
  output logic             ALUSrcB,
  output logic [2:0]       ALUOp,
  output logic             RegWre,
  output logic [1:0]       RegDst,
  output logic             WrRegDSrc,
  output logic             DBDataSrc,
  output logic             mRD,
  output logic             mWR,
  output logic [1:0]       PCSrc,
  output logic [2:0]       state,
  output logic             halted,
  output logic [CNT_W-1:0] instr_count
);

  localparam logic [5:0] OP_ADD  = 6'b000000;
  localparam logic [5:0] OP_SUB  = 6'b000001;
  localparam logic [5:0] OP_ADDI = 6'b000010;
  localparam logic [5:0] OP_ORI  = 6'b010000;
  localparam logic [5:0] OP_AND  = 6'b010001;
  localparam logic [5:0] OP_OR   = 6'b010010;
  localparam logic [5:0] OP_SLL  = 6'b011000;
  localparam logic [5:0] OP_SLTI = 6'b011100;
  localparam logic [5:0] OP_SW   = 6'b110000;
  localparam logic [5:0] OP_LW   = 6'b110001;
  localparam logic [5:0] OP_BEQ  = 6'b110100;
  localparam logic [5:0] OP_BNE  = 6'b110101;
  localparam logic [5:0] OP_J    = 6'b111000;
  localparam logic [5:0] OP_JR   = 6'b111001;
  localparam logic [5:0] OP_JAL  = 6'b111010;
  localparam logic [5:0] OP_HALT = 6'b111111;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_SLL = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_AND = 3'b100;
  localparam logic [2:0] ALU_SLT = 3'b110;

  typedef enum logic [2:0] {
    S_IF      = 3'b000,
    S_ID      = 3'b001,
    S_EXE_MEM = 3'b010,
    S_MEM     = 3'b011,
    S_WB_LD   = 3'b100,
    S_EXE_BR  = 3'b101,
    S_EXE_AL  = 3'b110,
    S_WB_AL   = 3'b111
  } state_e;

  state_e           state_q, state_d;
  logic             halted_q, halted_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic is_alu_r, is_alu_i, is_alu, is_mem, is_lw, is_sw, is_br, is_jmp, is_halt, is_nop;
  logic br_taken;
  logic [2:0] alu_op;

  // Opcode classification
  always_comb begin
    is_alu_r = 1'b0;
    is_alu_i = 1'b0;
    is_lw    = 1'b0;
    is_sw    = 1'b0;
    is_br    = 1'b0;
    is_jmp   = 1'b0;
    is_halt  = 1'b0;
    alu_op   = ALU_ADD;
    case (opcode)
      OP_ADD:  begin is_alu_r = 1'b1; alu_op = ALU_ADD; end
      OP_SUB:  begin is_alu_r = 1'b1; alu_op = ALU_SUB; end
      OP_AND:  begin is_alu_r = 1'b1; alu_op = ALU_AND; end
      OP_OR:   begin is_alu_r = 1'b1; alu_op = ALU_OR;  end
      OP_SLL:  begin is_alu_r = 1'b1; alu_op = ALU_SLL; end
      OP_ADDI: begin is_alu_i = 1'b1; alu_op = ALU_ADD; end
      OP_ORI:  begin is_alu_i = 1'b1; alu_op = ALU_OR;  end
      OP_SLTI: begin is_alu_i = 1'b1; alu_op = ALU_SLT; end
      OP_SW:   begin is_sw    = 1'b1; alu_op = ALU_ADD; end
      OP_LW:   begin is_lw    = 1'b1; alu_op = ALU_ADD; end
      OP_BEQ:  begin is_br    = 1'b1; alu_op = ALU_SUB; end
      OP_BNE:  begin is_br    = 1'b1; alu_op = ALU_SUB; end
      OP_J:    is_jmp  = 1'b1;
      OP_JR:   is_jmp  = 1'b1;
      OP_JAL:  is_jmp  = 1'b1;
      OP_HALT: is_halt = 1'b1;
      default: ;
    endcase
    is_alu   = is_alu_r | is_alu_i;
    is_mem   = is_lw | is_sw;
    is_nop   = ~(is_alu | is_mem | is_br | is_jmp | is_halt);
    br_taken = ((opcode == OP_BEQ) && zero) || ((opcode == OP_BNE) && !zero);
  end

  // Next-state and counter update
  always_comb begin
    state_d  = state_q;
    halted_d = halted_q;
    cnt_d    = cnt_q + (PCWre ? CNT_W'(1) : CNT_W'(0));
    if (!halted_q) begin
      case (state_q)
        S_IF: state_d = S_ID;
        S_ID: begin
          if (is_halt) begin
            halted_d = 1'b1;
            state_d  = S_IF;
          end else if (is_br) begin
            state_d = S_EXE_BR;
          end else if (is_mem) begin
            state_d = S_EXE_MEM;
          end else if (is_alu) begin
            state_d = S_EXE_AL;
          end else begin
            state_d = S_IF;
          end
        end
        S_EXE_AL:  state_d = S_WB_AL;
        S_WB_AL:   state_d = S_IF;
        S_EXE_BR:  state_d = S_IF;
        S_EXE_MEM: state_d = S_MEM;
        S_MEM:     state_d = is_lw ? S_WB_LD : S_IF;
        S_WB_LD:   state_d = S_IF;
        default:   state_d = S_IF;
      endcase
    end
    if (Reset) begin
      state_d  = S_IF;
      halted_d = 1'b0;
      cnt_d    = '0;
    end
  end

  always_ff @(posedge CLK) begin
    state_q  <= state_d;
    halted_q <= halted_d;
    cnt_q    <= cnt_d;
  end

  // Datapath controls; opcode-derived selects stay valid from ID to retirement
  always_comb begin
    PCWre     = 1'b0;
    InsMemRW  = 1'b0;
    IRWre     = 1'b0;
    RegWre    = 1'b0;
    RegDst    = 2'b00;
    WrRegDSrc = 1'b0;
    DBDataSrc = 1'b0;
    mRD       = 1'b0;
    mWR       = 1'b0;
    PCSrc     = 2'b00;
    ExtSel    = is_alu_i & (opcode != OP_ORI) | is_mem | is_br;
    ALUSrcA   = (opcode == OP_SLL);
    ALUSrcB   = is_alu_i | is_mem;
    ALUOp     = alu_op;
    if (!halted_q) begin
      case (state_q)
        S_IF: begin
          InsMemRW = 1'b1;
          IRWre    = 1'b1;
        end
        S_ID: begin
          PCWre = is_jmp | is_nop;
          if (opcode == OP_J || opcode == OP_JAL) PCSrc = 2'b11;
          if (opcode == OP_JR) PCSrc = 2'b10;
          if (opcode == OP_JAL) begin
            RegWre    = 1'b1;
            RegDst    = 2'b00;
            WrRegDSrc = 1'b0;
          end
        end
        S_EXE_BR: begin
          PCWre = 1'b1;
          PCSrc = br_taken ? 2'b01 : 2'b00;
        end
        S_WB_AL: begin
          PCWre     = 1'b1;
          RegWre    = 1'b1;
          WrRegDSrc = 1'b1;
          DBDataSrc = 1'b0;
          RegDst    = is_alu_i ? 2'b01 : 2'b10;
        end
        S_MEM: begin
          if (is_lw) begin
            mRD       = 1'b1;
            DBDataSrc = 1'b1;
          end else begin
            mWR   = 1'b1;
            PCWre = 1'b1;
          end
        end
        S_WB_LD: begin
          PCWre     = 1'b1;
          mRD       = 1'b1;
          DBDataSrc = 1'b1;
          RegWre    = 1'b1;
          RegDst    = 2'b01;
          WrRegDSrc = 1'b1;
        end
        default: ;
      endcase
    end
    // Nothing may be written while reset is held, whatever state we are in
    if (Reset) begin
      PCWre  = 1'b0;
      IRWre  = 1'b0;
      RegWre = 1'b0;
      mWR    = 1'b0;
      mRD    = 1'b0;
    end
  end

  assign state       = state_q;
  assign halted      = halted_q;
  assign instr_count = cnt_q;

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Randomized bench for multicycle_control_unit against an instruction-level model.
module tb_multicycle_control_unit;

  localparam int unsigned CNT_W = 32;

  localparam int K_JMP  = 0;
  localparam int K_HALT = 1;
  localparam int K_BR   = 2;
  localparam int K_ALU  = 3;
  localparam int K_SW   = 4;
  localparam int K_LW   = 5;

  logic CLK, Reset, zero;
  logic [5:0] opcode;
  logic PCWre, InsMemRW, IRWre, ExtSel, ALUSrcA, ALUSrcB, RegWre, WrRegDSrc, DBDataSrc;
  logic mRD, mWR, halted;
  logic [2:0] ALUOp, state;
  logic [1:0] RegDst, PCSrc;
  logic [CNT_W-1:0] instr_count;

  int n_checks = 0;
  int n_fail   = 0;
  logic [CNT_W-1:0] model_cnt = '0;

  multicycle_control_unit #(.CNT_W(CNT_W)) dut (
    .CLK(CLK), .Reset(Reset), .opcode(opcode), .zero(zero),
    .PCWre(PCWre), .InsMemRW(InsMemRW), .IRWre(IRWre), .ExtSel(ExtSel),
    .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ALUOp(ALUOp), .RegWre(RegWre),
    .RegDst(RegDst), .WrRegDSrc(WrRegDSrc), .DBDataSrc(DBDataSrc),
    .mRD(mRD), .mWR(mWR), .PCSrc(PCSrc), .state(state), .halted(halted),
    .instr_count(instr_count)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
    end
  endtask

  function automatic int kind_of(input logic [5:0] op);
    case (op)
      6'b000000, 6'b000001, 6'b000010, 6'b010000,
      6'b010001, 6'b010010, 6'b011000, 6'b011100: return K_ALU;
      6'b110000: return K_SW;
      6'b110001: return K_LW;
      6'b110100, 6'b110101: return K_BR;
      6'b111111: return K_HALT;
      default: return K_JMP;
    endcase
  endfunction

  function automatic logic [2:0] exp_aluop(input logic [5:0] op);
    case (op)
      6'b000001, 6'b110100, 6'b110101: return 3'b001;
      6'b011000: return 3'b010;
      6'b010000, 6'b010010: return 3'b011;
      6'b010001: return 3'b100;
      6'b011100: return 3'b110;
      default: return 3'b000;
    endcase
  endfunction

  function automatic logic is_imm(input logic [5:0] op);
    return op == 6'b000010 || op == 6'b010000 || op == 6'b011100;
  endfunction

  // Runs one instruction from its IF cycle; abort_i >= 0 raises Reset in that cycle and returns.
  task automatic run_instr(input logic [5:0] op, input logic z, input int abort_i);
    int kind;
    int lat;
    logic last, e_pcwre, e_regwre, e_mrd, e_mwr, e_ext;
    logic [1:0] e_pcsrc;
    logic [2:0] seq[$];
    kind = kind_of(op);
    seq = {3'b000, 3'b001};
    if (kind == K_BR) seq.push_back(3'b101);
    if (kind == K_ALU) begin seq.push_back(3'b110); seq.push_back(3'b111); end
    if (kind == K_SW || kind == K_LW) begin seq.push_back(3'b010); seq.push_back(3'b011); end
    if (kind == K_LW) seq.push_back(3'b100);
    lat = seq.size();
    e_ext = (op == 6'b000010 || op == 6'b011100 || kind == K_SW || kind == K_LW || kind == K_BR);
    e_pcwre = 1'b0;
    for (int i = 0; i < lat; i++) begin
      if (i > 0) @(negedge CLK);
      if (i == 0) begin opcode = op; zero = z; end
      if (i == abort_i) Reset = 1'b1;
      #1;
      if (i == abort_i) begin
        check("abort_state", state, seq[i]);
        check("abort_mwr", mWR, 0);
        check("abort_mrd", mRD, 0);
        check("abort_pcwre", PCWre, 0);
        check("abort_regwre", RegWre, 0);
        return;
      end
      last     = (i == lat - 1);
      e_pcwre  = last && kind != K_HALT;
      e_regwre = (kind == K_ALU && i == 3) || (kind == K_LW && i == 4) || (op == 6'b111010 && i == 1);
      e_mrd    = kind == K_LW && i >= 3;
      e_mwr    = kind == K_SW && i == 3;
      e_pcsrc  = 2'b00;
      if (i == 1 && (op == 6'b111000 || op == 6'b111010)) e_pcsrc = 2'b11;
      if (i == 1 && op == 6'b111001) e_pcsrc = 2'b10;
      if (i == 2 && kind == K_BR && ((op == 6'b110100) ? z : !z)) e_pcsrc = 2'b01;
      if (i == 0) check("instr_count", instr_count, model_cnt);
      check("state", state, seq[i]);
      check("halted", halted, 0);
      check("pcwre", PCWre, e_pcwre);
      check("irwre", IRWre, i == 0);
      check("insmemrw", InsMemRW, i == 0);
      check("regwre", RegWre, e_regwre);
      check("mrd", mRD, e_mrd);
      check("mwr", mWR, e_mwr);
      check("pcsrc", PCSrc, e_pcsrc);
      if (i >= 1) check("extsel", ExtSel, e_ext);
      if (i == 2 && kind != K_JMP && kind != K_HALT) check("aluop", ALUOp, exp_aluop(op));
      if (i >= 2 && (kind == K_ALU || kind == K_SW || kind == K_LW))
        check("alusrcb", ALUSrcB, is_imm(op) || kind == K_SW || kind == K_LW);
      if (i >= 2 && kind == K_ALU) check("alusrca", ALUSrcA, op == 6'b011000);
      if (e_regwre) begin
        check("regdst", RegDst, (op == 6'b111010) ? 2'b00 : ((kind == K_LW || is_imm(op)) ? 2'b01 : 2'b10));
        check("wrregdsrc", WrRegDSrc, op != 6'b111010);
      end
      if (e_regwre || e_mrd) check("dbdatasrc", DBDataSrc, kind == K_LW);
    end
    if (e_pcwre) model_cnt = model_cnt + 1;
    @(negedge CLK);
  endtask

  task automatic reset_release;
    @(negedge CLK);
    Reset = 1'b0;
    #1;
    model_cnt = '0;
    check("rst_state", state, 0);
    check("rst_halted", halted, 0);
    check("rst_count", instr_count, 0);
  endtask

  logic [5:0] ops [15] = '{6'b000000, 6'b000001, 6'b000010, 6'b010000, 6'b010001,
                           6'b010010, 6'b011000, 6'b011100, 6'b110000, 6'b110001,
                           6'b110100, 6'b110101, 6'b111000, 6'b111001, 6'b111010};

  initial begin
    logic [5:0] op;
    Reset = 1'b1;
    opcode = 6'b0;
    zero = 1'b0;
    repeat (2) @(negedge CLK);
    #1;
    check("init_state", state, 0);
    check("init_halted", halted, 0);
    check("init_count", instr_count, 0);
    check("init_pcwre", PCWre, 0);
    check("init_irwre", IRWre, 0);
    Reset = 1'b0;

    run_instr(6'b000010, 1'b0, -1);
    run_instr(6'b110001, 1'b0, -1);
    run_instr(6'b110100, 1'b1, -1);
    run_instr(6'b110100, 1'b0, -1);
    run_instr(6'b010000, 1'b0, -1);

    for (int n = 0; n < 80; n++) begin
      if ($urandom_range(0, 4) == 0) begin
        op = 6'($urandom());
        if (op == 6'b111111) op = 6'b111110;
      end else begin
        op = ops[$urandom_range(0, 14)];
      end
      run_instr(op, 1'($urandom()), -1);
    end

    run_instr(6'b110000, 1'b0, 3);
    reset_release();
    run_instr(6'b111010, 1'b0, -1);
    run_instr(6'b111111, 1'b0, -1);
    for (int c = 0; c < 20; c++) begin
      #1;
      check("halt_state", state, 0);
      check("halt_flag", halted, 1);
      check("halt_pcwre", PCWre, 0);
      check("halt_count", instr_count, model_cnt);
      @(negedge CLK);
    end
    Reset = 1'b1;
    #1;
    check("halt_rst_pcwre", PCWre, 0);
    reset_release();
    run_instr(6'b000000, 1'b0, -1);
    check("final_count", instr_count, model_cnt);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
